// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 geometry, frame-size
// helpers and the coordinate type used by the timing generator and renderers.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int h_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int v_total(input int visible, input int front,
                                 input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register with a per-bit reset pattern, used to line up
// sync/blank with the renderer pipeline.
module vga_sync_delay #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, vga_clk, reset};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync and blank
// decodes aligned with DrawX/DrawY, plus pipeline-delayed copies for the pins.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_DELAY = 2
) (
  input  logic   vga_clk,
  input  logic   reset,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   blank,
  output logic   hs,
  output logic   vs,
  output logic   hs_d,
  output logic   vs_d,
  output logic   blank_d,
  output logic   line_start,
  output logic   frame_start
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_delay_check
    $error("vga_timing_gen: SYNC_DELAY must be 0..4");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t hc, vc;
  coord_t hc_nxt, vc_nxt;
  logic [2:0] dly_q;

  always_comb begin
    hc_nxt = hc + 10'd1;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      hc_nxt = '0;
      vc_nxt = (vc == V_LAST) ? '0 : vc + 10'd1;
    end
  end

  // Decodes look at the next counter values so they land with the counters.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      blank       <= (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
      hs          <= !((hc_nxt >= HS_FIRST) && (hc_nxt <= HS_LAST));
      vs          <= !((vc_nxt >= VS_FIRST) && (vc_nxt <= VS_LAST));
      line_start  <= (hc_nxt == '0);
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  // Delay stages reset to "syncs idle, nothing visible".
  vga_sync_delay #(
    .DEPTH   (SYNC_DELAY),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .d       ({hs, vs, blank}),
    .q       (dly_q)
  );

  assign {hs_d, vs_d, blank_d} = dly_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (delay 2) and a reduced
// geometry instance (delay 0) compared against an arithmetic raster model.
module tb_vga_timing_gen;

  typedef struct {
    int hv, hf, hsw, hb, vv, vf, vsw, vb, d;
  } geo_t;

  typedef struct {
    int x, y;
    bit bl, hs, vs, ls, fs;
  } sig_t;

  typedef struct {
    int n, x, y;
    bit bl, hs, vs, ls, fs, hsd, bld;
  } vec_t;

  localparam geo_t GB = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam geo_t GS = '{8, 2, 3, 3, 6, 1, 2, 2, 0};

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  logic [9:0] b_x, b_y, s_x, s_y;
  logic b_blank, b_hs, b_vs, b_hs_d, b_vs_d, b_blank_d, b_ls, b_fs;
  logic s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_blank_d, s_ls, s_fs;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen u_big (
    .vga_clk(vga_clk), .reset(reset), .DrawX(b_x), .DrawY(b_y),
    .blank(b_blank), .hs(b_hs), .vs(b_vs), .hs_d(b_hs_d), .vs_d(b_vs_d),
    .blank_d(b_blank_d), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(0)
  ) u_small (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y),
    .blank(s_blank), .hs(s_hs), .vs(s_vs), .hs_d(s_hs_d), .vs_d(s_vs_d),
    .blank_d(s_blank_d), .line_start(s_ls), .frame_start(s_fs)
  );

  int passed = 0;
  int total  = 0;
  int n      = 0;

  bit fs_seen, ls_seen, have_prev, prev_vs;
  int last_fs, vs_cnt, bl_cnt, last_ls, hs_cnt, prev_x, prev_y;

  vec_t tbl[16];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at n=%0d: got %0d expected %0d", nm, n, act, exp);
  endtask

  // Pixel position is just the cycle count since reset folded onto the raster.
  function automatic sig_t model(input geo_t g, input int k);
    sig_t s;
    int ht = g.hv + g.hf + g.hsw + g.hb;
    int vt = g.vv + g.vf + g.vsw + g.vb;
    s.x  = k % ht;
    s.y  = (k / ht) % vt;
    s.bl = (s.x < g.hv) && (s.y < g.vv);
    s.hs = !((s.x >= g.hv + g.hf) && (s.x < g.hv + g.hf + g.hsw));
    s.vs = !((s.y >= g.vv + g.vf) && (s.y < g.vv + g.vf + g.vsw));
    s.ls = (s.x == 0);
    s.fs = (s.x == 0) && (s.y == 0);
    return s;
  endfunction

  function automatic sig_t model_d(input geo_t g, input int k);
    sig_t s;
    if (k < g.d) begin
      s = model(g, 0);
      s.hs = 1'b1; s.vs = 1'b1; s.bl = 1'b0;
    end else begin
      s = model(g, k - g.d);
    end
    return s;
  endfunction

  task automatic clear_stats();
    fs_seen = 0; ls_seen = 0; have_prev = 0;
    vs_cnt = 0; bl_cnt = 0; hs_cnt = 0;
  endtask

  task automatic check_cycle();
    sig_t e, d;
    e = model(GB, n); d = model_d(GB, n);
    chk("b_DrawX", int'(b_x), e.x);     chk("b_DrawY", int'(b_y), e.y);
    chk("b_blank", int'(b_blank), int'(e.bl));
    chk("b_hs", int'(b_hs), int'(e.hs)); chk("b_vs", int'(b_vs), int'(e.vs));
    chk("b_line_start", int'(b_ls), int'(e.ls));
    chk("b_frame_start", int'(b_fs), int'(e.fs));
    chk("b_hs_d", int'(b_hs_d), int'(d.hs)); chk("b_vs_d", int'(b_vs_d), int'(d.vs));
    chk("b_blank_d", int'(b_blank_d), int'(d.bl));
    e = model(GS, n); d = model_d(GS, n);
    chk("s_DrawX", int'(s_x), e.x);     chk("s_DrawY", int'(s_y), e.y);
    chk("s_blank", int'(s_blank), int'(e.bl));
    chk("s_hs", int'(s_hs), int'(e.hs)); chk("s_vs", int'(s_vs), int'(e.vs));
    chk("s_line_start", int'(s_ls), int'(e.ls));
    chk("s_frame_start", int'(s_fs), int'(e.fs));
    chk("s_hs_d", int'(s_hs_d), int'(d.hs)); chk("s_vs_d", int'(s_vs_d), int'(d.vs));
    chk("s_blank_d", int'(s_blank_d), int'(d.bl));

    // Frame-level properties of the small raster (16 x 11 = 176 clocks).
    if (s_fs) begin
      if (fs_seen) begin
        chk("s_frame_period", n - last_fs, 176);
        chk("s_vs_low_cycles", vs_cnt, 32);
        chk("s_visible_cycles", bl_cnt, 48);
      end
      fs_seen = 1; last_fs = n; vs_cnt = 0; bl_cnt = 0;
    end
    if (!s_vs) vs_cnt++;
    if (s_blank) bl_cnt++;
    if (have_prev) begin
      if (prev_vs && !s_vs) begin
        chk("s_vs_fall_x", int'(s_x), 0); chk("s_vs_fall_y", int'(s_y), 7);
      end
      if (!prev_vs && s_vs) begin
        chk("s_vs_last_x", prev_x, 15); chk("s_vs_last_y", prev_y, 8);
      end
      if (prev_y == 10 && int'(s_y) != 10) chk("s_DrawY_wrap", int'(s_y), 0);
    end
    have_prev = 1; prev_vs = s_vs; prev_x = int'(s_x); prev_y = int'(s_y);

    // Line-level properties of the full-size raster.
    if (b_ls) begin
      if (ls_seen) begin
        chk("b_line_period", n - last_ls, 800);
        chk("b_hs_low_cycles", hs_cnt, 96);
      end
      ls_seen = 1; last_ls = n; hs_cnt = 0;
    end
    if (!b_hs) hs_cnt++;
  endtask

  task automatic run_cycles(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge vga_clk);
      n++;
      check_cycle();
    end
  endtask

  // Assert reset between edges; outputs must change before any clock edge.
  task automatic async_reset(input int off, input int hold);
    #(off);
    reset = 1'b1;
    #1;
    chk("rst_b_DrawX", int'(b_x), 0);   chk("rst_b_DrawY", int'(b_y), 0);
    chk("rst_b_blank", int'(b_blank), 1);
    chk("rst_b_hs", int'(b_hs), 1);     chk("rst_b_vs", int'(b_vs), 1);
    chk("rst_b_line_start", int'(b_ls), 1);
    chk("rst_b_frame_start", int'(b_fs), 1);
    chk("rst_b_hs_d", int'(b_hs_d), 1); chk("rst_b_vs_d", int'(b_vs_d), 1);
    chk("rst_b_blank_d", int'(b_blank_d), 0);
    chk("rst_s_DrawX", int'(s_x), 0);   chk("rst_s_DrawY", int'(s_y), 0);
    chk("rst_s_blank_d", int'(s_blank_d), 1);
    repeat (hold + 1) @(negedge vga_clk);
    reset = 1'b0;
    n = 0;
    clear_stats();
    check_cycle();
  endtask

  initial begin
    tbl[0]  = '{0,    0,   0, 1, 1, 1, 1, 1, 1, 0};
    tbl[1]  = '{1,    1,   0, 1, 1, 1, 0, 0, 1, 0};
    tbl[2]  = '{2,    2,   0, 1, 1, 1, 0, 0, 1, 1};
    tbl[3]  = '{639,  639, 0, 1, 1, 1, 0, 0, 1, 1};
    tbl[4]  = '{640,  640, 0, 0, 1, 1, 0, 0, 1, 1};
    tbl[5]  = '{641,  641, 0, 0, 1, 1, 0, 0, 1, 1};
    tbl[6]  = '{642,  642, 0, 0, 1, 1, 0, 0, 1, 0};
    tbl[7]  = '{655,  655, 0, 0, 1, 1, 0, 0, 1, 0};
    tbl[8]  = '{656,  656, 0, 0, 0, 1, 0, 0, 1, 0};
    tbl[9]  = '{658,  658, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{751,  751, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{752,  752, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[12] = '{799,  799, 0, 0, 1, 1, 0, 0, 1, 0};
    tbl[13] = '{800,  0,   1, 1, 1, 1, 1, 0, 1, 0};
    tbl[14] = '{1439, 639, 1, 1, 1, 1, 0, 0, 1, 1};
    tbl[15] = '{1440, 640, 1, 0, 1, 1, 0, 0, 1, 1};

    reset = 1'b1;
    repeat (3) @(negedge vga_clk);
    reset = 1'b0;
    n = 0;
    clear_stats();
    check_cycle();

    // Directed vectors on the full-size raster, up to pixel (300,2).
    for (int ti = 0, k = 0; k <= 1900; k++) begin
      if (k > 0) begin
        @(negedge vga_clk);
        n++;
        check_cycle();
      end
      if (ti < 16 && tbl[ti].n == n) begin
        chk("tv_DrawX", int'(b_x), tbl[ti].x);
        chk("tv_DrawY", int'(b_y), tbl[ti].y);
        chk("tv_blank", int'(b_blank), int'(tbl[ti].bl));
        chk("tv_hs", int'(b_hs), int'(tbl[ti].hs));
        chk("tv_vs", int'(b_vs), int'(tbl[ti].vs));
        chk("tv_line_start", int'(b_ls), int'(tbl[ti].ls));
        chk("tv_frame_start", int'(b_fs), int'(tbl[ti].fs));
        chk("tv_hs_d", int'(b_hs_d), int'(tbl[ti].hsd));
        chk("tv_blank_d", int'(b_blank_d), int'(tbl[ti].bld));
        ti++;
      end
    end
    chk("pos_before_reset_x", int'(b_x), 300);
    chk("pos_before_reset_y", int'(b_y), 2);
    async_reset(2, 0);

    // Post-reset restart: clean frame_start then advance to (1,0).
    chk("restart_frame_start", int'(b_fs), 1);
    run_cycles(1);
    chk("restart_DrawX", int'(b_x), 1);
    chk("restart_frame_start_low", int'(b_fs), 0);
    run_cycles(600);

    // Random run lengths and random asynchronous reset points.
    for (int r = 0; r < 10; r++) begin
      run_cycles(int'($urandom_range(1, 2500)));
      async_reset(int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end
    run_cycles(400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
